// File: rtl/fiber_pkg.sv
// Shared definitions for the fiber receive deserializer: frame width,
// receiver FSM encoding and the counter-width helper.
package fiber_pkg;

   localparam int unsigned DATA_BITS_SIZES = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_t;

   // Bits needed to hold max_value, never fewer than min_bits.
   function automatic int unsigned cnt_width(input int unsigned max_value,
                                             input int unsigned min_bits);
      int unsigned w;
      w = 1;
      while ((64'd1 << w) <= 64'(max_value)) w++;
      return (w < min_bits) ? min_bits : w;
   endfunction

endpackage

// File: rtl/fiber_in_sync.sv
// Two-flop synchronizer for the raw fiber line plus a registered
// falling-edge detect on the synchronized value. Idle level is high.
module fiber_in_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic fiber_in,
   output logic rx_s,
   output logic rx_fall
);

   logic meta;
   logic sync;
   logic sync_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta   <= 1'b1;
         sync   <= 1'b1;
         sync_d <= 1'b1;
      end else begin
         meta   <= fiber_in;
         sync   <= meta;
         sync_d <= sync;
      end
   end

   assign rx_s    = sync;
   assign rx_fall = sync_d & ~sync;

endmodule

// File: rtl/fiber_rx_deser.sv
// Fiber line receiver: start/data/stop framing with centre sampling,
// stop-bit error counting and a microsecond link-loss timer.
module fiber_rx_deser #(
   parameter int unsigned DATA_BITS_SIZES = fiber_pkg::DATA_BITS_SIZES,
   parameter int unsigned BIT_CLKS        = 50,
   parameter int unsigned LINK_TIMEOUT_US = 1000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       time_1us,
   input  logic                       fiber_in,
   input  logic                       reset_unit,
   output logic [DATA_BITS_SIZES-1:0] rx_data_syn,
   output logic                       end_flag,
   output logic                       frame_err,
   output logic [3:0]                 frame_err_cnt,
   output logic                       link_lost
);

   import fiber_pkg::*;

   localparam int unsigned CNT_W = cnt_width(BIT_CLKS - 1, 1);
   localparam int unsigned BIT_W = cnt_width(DATA_BITS_SIZES, 1);
   localparam int unsigned LT_W  = cnt_width(LINK_TIMEOUT_US, 10);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CLKS / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS_SIZES - 1);
   localparam logic [LT_W-1:0]  LT_MAX    = LT_W'(LINK_TIMEOUT_US);
   localparam logic [LT_W-1:0]  LT_PRE    = LT_W'(LINK_TIMEOUT_US - 1);

   logic                       rx_s;
   logic                       rx_fall;
   rx_state_t                  state;
   rx_state_t                  state_next;
   logic [CNT_W-1:0]           clk_cnt;
   logic [BIT_W-1:0]           bit_cnt;
   logic [DATA_BITS_SIZES-1:0] shreg;
   logic [LT_W-1:0]            link_timer;
   logic                       cnt_clr;
   logic                       data_tick;
   logic                       stop_tick;
   logic                       good_frame;
   logic                       bad_frame;

   fiber_in_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .fiber_in (fiber_in),
      .rx_s     (rx_s),
      .rx_fall  (rx_fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      cnt_clr    = 1'b0;
      data_tick  = 1'b0;
      stop_tick  = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            if (rx_fall) state_next = ST_START;
         end
         ST_START: begin
            // Line must still be low at mid start bit, otherwise it was a glitch.
            if (clk_cnt == HALF_LAST) begin
               cnt_clr    = 1'b1;
               state_next = rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (clk_cnt == BIT_LAST) begin
               cnt_clr   = 1'b1;
               data_tick = 1'b1;
               if (bit_cnt == LAST_BIT) state_next = ST_STOP;
            end
         end
         ST_STOP: begin
            if (clk_cnt == BIT_LAST) begin
               cnt_clr    = 1'b1;
               stop_tick  = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign good_frame = stop_tick & rx_s;
   assign bad_frame  = stop_tick & ~rx_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         clk_cnt <= cnt_clr ? '0 : clk_cnt + 1'b1;
         if (state != ST_DATA) bit_cnt <= '0;
         else if (data_tick)   bit_cnt <= bit_cnt + 1'b1;
         if (data_tick) shreg <= {shreg[DATA_BITS_SIZES-2:0], rx_s};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data_syn   <= '0;
         end_flag      <= 1'b0;
         frame_err     <= 1'b0;
         frame_err_cnt <= '0;
      end else begin
         end_flag  <= good_frame;
         frame_err <= bad_frame;
         if (good_frame) rx_data_syn <= shreg;
         if (reset_unit)                            frame_err_cnt <= '0;
         else if (bad_frame && frame_err_cnt != '1) frame_err_cnt <= frame_err_cnt + 1'b1;
      end
   end

   // Timer clears on the stop sample so link_lost is already low when end_flag shows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         link_timer <= '0;
         link_lost  <= 1'b0;
      end else if (reset_unit || good_frame) begin
         link_timer <= '0;
         link_lost  <= 1'b0;
      end else if (time_1us && link_timer != LT_MAX) begin
         link_timer <= link_timer + 1'b1;
         if (link_timer == LT_PRE) link_lost <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fiber_rx_deser.sv
// Randomized self-checking bench for fiber_rx_deser against a frame-level
// reference model (expected-event queue, last good word, error count).
module tb_fiber_rx_deser;

   localparam int unsigned BIT_CLKS = 8;
   localparam int unsigned LINK_US  = 20;
   localparam int unsigned DW       = 5;

   logic          clk        = 1'b0;
   logic          rst_n      = 1'b0;
   logic          time_1us   = 1'b0;
   logic          fiber_in   = 1'b1;
   logic          reset_unit = 1'b0;
   logic [DW-1:0] rx_data_syn;
   logic          end_flag;
   logic          frame_err;
   logic [3:0]    frame_err_cnt;
   logic          link_lost;

   int unsigned   n_checks = 0;
   int unsigned   n_fail   = 0;
   int unsigned   n_events = 0;
   int unsigned   psg      = 0;
   logic [5:0]    exp_q[$];
   logic [5:0]    mon_e;
   logic [DW-1:0] exp_rx   = '0;
   logic [3:0]    exp_cnt  = '0;

   fiber_rx_deser #(
      .DATA_BITS_SIZES (DW),
      .BIT_CLKS        (BIT_CLKS),
      .LINK_TIMEOUT_US (LINK_US)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .time_1us      (time_1us),
      .fiber_in      (fiber_in),
      .reset_unit    (reset_unit),
      .rx_data_syn   (rx_data_syn),
      .end_flag      (end_flag),
      .frame_err     (frame_err),
      .frame_err_cnt (frame_err_cnt),
      .link_lost     (link_lost)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         repeat (49) @(posedge clk);
         #1 time_1us = 1'b1;
         @(posedge clk);
         #1 time_1us = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every end_flag/frame_err pulse must match the oldest frame sent.
   always @(negedge clk) begin
      if (rst_n) begin
         if (end_flag) psg = 0;
         if (time_1us) psg++;
         if (end_flag || frame_err) begin
            n_events++;
            if (exp_q.size() == 0) begin
               check("unexpected_event", {30'd0, end_flag, frame_err}, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               if (!mon_e[5]) begin
                  exp_rx = mon_e[DW-1:0];
                  check("end_flag", end_flag, 1);
                  check("no_err_on_good", frame_err, 0);
                  check("rx_data", rx_data_syn, exp_rx);
                  check("link_low_on_good", link_lost, 0);
                  check("err_cnt_on_good", frame_err_cnt, exp_cnt);
               end else begin
                  exp_cnt = (exp_cnt == 4'd15) ? 4'd15 : exp_cnt + 4'd1;
                  check("frame_err", frame_err, 1);
                  check("no_end_on_err", end_flag, 0);
                  check("rx_hold_on_err", rx_data_syn, exp_rx);
                  check("err_cnt", frame_err_cnt, exp_cnt);
               end
            end
         end
      end
   end

   task automatic drive_bit(input logic b);
      fiber_in = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input logic stop_ok);
      exp_q.push_back({~stop_ok, d});
      drive_bit(1'b0);
      for (int i = DW - 1; i >= 0; i--) drive_bit(d[i]);
      drive_bit(stop_ok);
      fiber_in = 1'b1;
   endtask

   task automatic idle(input int unsigned n);
      fiber_in = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
      check("pending_events", exp_q.size(), 0);
   endtask

   initial begin
      logic [DW-1:0] d;
      logic          ok;
      int unsigned   ev0;
      int unsigned   guard;

      repeat (3) @(negedge clk);
      check("rst_rx_data", rx_data_syn, 0);
      check("rst_end_flag", end_flag, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_err_cnt", frame_err_cnt, 0);
      check("rst_link_lost", link_lost, 0);
      rst_n = 1'b1;
      idle(10);

      send_frame(5'b10110, 1'b1);
      idle(8);
      drain();

      ev0 = n_events;
      fiber_in = 1'b0;
      repeat (3) @(negedge clk);
      idle(30);
      check("glitch_no_event", n_events, ev0);

      send_frame(5'b01101, 1'b0);
      idle(10);
      drain();
      check("err_cnt_one", frame_err_cnt, 1);
      check("rx_keeps_prior", rx_data_syn, 5'b10110);

      send_frame(5'b11110, 1'b1);
      send_frame(5'b00011, 1'b1);
      idle(8);
      drain();
      check("b2b_last", rx_data_syn, 5'b00011);

      for (int k = 0; k < 40; k++) begin
         d  = DW'($urandom_range(0, 31));
         ok = ($urandom_range(0, 5) != 0);
         send_frame(d, ok);
         idle(ok ? $urandom_range(0, 12) : 8 + $urandom_range(0, 12));
      end
      drain();

      for (int k = 0; k < 16; k++) begin
         send_frame(DW'($urandom_range(0, 31)), 1'b0);
         idle(10);
      end
      drain();
      check("err_cnt_saturated", frame_err_cnt, 15);

      reset_unit = 1'b1;
      @(negedge clk);
      reset_unit = 1'b0;
      exp_cnt = '0;
      check("reset_unit_cnt", frame_err_cnt, 0);
      check("reset_unit_link", link_lost, 0);
      check("reset_unit_rx_kept", rx_data_syn, exp_rx);

      send_frame(5'b10011, 1'b1);
      idle(8);
      drain();
      guard = 0;
      while (psg < LINK_US - 1 && guard < 1500) begin
         @(negedge clk); #1; guard++;
      end
      check("link_wait19_bound", guard < 1500, 1);
      @(negedge clk);
      check("link_before_timeout", link_lost, 0);
      while (psg < LINK_US && guard < 1500) begin
         @(negedge clk); #1; guard++;
      end
      check("link_wait20_bound", guard < 1500, 1);
      @(negedge clk);
      check("link_lost_set", link_lost, 1);
      repeat (60) @(negedge clk);
      check("link_lost_held", link_lost, 1);
      send_frame(5'b01010, 1'b1);
      idle(8);
      drain();
      check("link_cleared", link_lost, 0);

      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b0);
      fiber_in = 1'b1;
      repeat (BIT_CLKS / 2) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_rx_data", rx_data_syn, 0);
      check("midrst_end_flag", end_flag, 0);
      check("midrst_frame_err", frame_err, 0);
      check("midrst_err_cnt", frame_err_cnt, 0);
      check("midrst_link_lost", link_lost, 0);
      exp_rx  = '0;
      exp_cnt = '0;
      rst_n   = 1'b1;
      ev0     = n_events;
      idle(40);
      check("midrst_no_event", n_events, ev0);
      exp_rx = 5'b11111;
      send_frame(5'b00000, 1'b1);
      idle(8);
      drain();
      check("post_rst_frame", rx_data_syn, 0);

      idle(20);
      check("final_pending", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fiber_rx_deser.md
FIBER_RX_DESER -- requirements
Module: fiber_rx_deser

Interface
REQ-001 Parameter DATA_BITS_SIZES, 5, frame payload width: 4 command bits plus 1 parity bit, MSB first on the line.
REQ-002 Parameter BIT_CLKS, 50, clk cycles per line bit; legal range 4..255.
REQ-003 Parameter LINK_TIMEOUT_US, 1000, microseconds without a good frame before link_lost is asserted.
REQ-004 clk  input  1  sole clock; all state is on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 time_1us  input  1  one-clk-wide pulse every 1 us, synchronous to clk.
REQ-007 fiber_in  input  1  raw optical receiver line, asynchronous to clk, idle high.
REQ-008 reset_unit  input  1  synchronous clear of link_lost and frame_err_cnt.
REQ-009 rx_data_syn  output  DATA_BITS_SIZES  last received frame, parity bit unchecked, in bit 0.
REQ-010 end_flag  output  1  one-clk pulse: rx_data_syn is newly valid.
REQ-011 frame_err  output  1  one-clk pulse: stop bit was sampled low.
REQ-012 frame_err_cnt  output  4  saturating count of stop-bit errors.
REQ-013 link_lost  output  1  no good frame for LINK_TIMEOUT_US microseconds.

Function
REQ-014 fiber_in passes through a 2-flop synchronizer; all logic uses the synchronized value (rx_s).
- Line frame: start bit 0, then DATA_BITS_SIZES data bits MSB first, then stop bit 1.
REQ-015 FSM states and transitions:
- IDLE: go to START on an rx_s 1->0 edge; clear clk_cnt.
- START: at clk_cnt = BIT_CLKS/2-1, if rx_s=0 go to DATA, else return to IDLE (glitch rejection).
- DATA: sample rx_s every BIT_CLKS cycles at bit centre into a shift register; after DATA_BITS_SIZES samples go to STOP.
- STOP: sample rx_s at bit centre, then return to IDLE.
REQ-016 In STOP, if the sample is 1: load rx_data_syn from the shift register and pulse end_flag in the same clk, exactly 1 cycle after the stop sample.
REQ-017 In STOP, if the sample is 0: pulse frame_err; leave rx_data_syn unchanged; no end_flag; increment frame_err_cnt, saturating at 15.
REQ-018 rx_data_syn holds its value between frames and is never cleared by errors.
REQ-019 A new start edge is accepted in IDLE in the cycle immediately after STOP exits; back-to-back frames lose no data.
REQ-020 Link timer: a 10-bit-min microsecond counter advances on time_1us.
- Cleared by every end_flag.
- When it reaches LINK_TIMEOUT_US, set link_lost and hold the counter there.
REQ-021 link_lost clears on the next end_flag or on reset_unit.
- If reset_unit and end_flag coincide, the result is cleared and the timer is zeroed.
REQ-022 reset_unit does not disturb the FSM or rx_data_syn.
- It zeroes frame_err_cnt.
- It has priority over a simultaneous increment.
REQ-023 Counter widths are sized by constant functions of BIT_CLKS and LINK_TIMEOUT_US; no wrap is possible.

Reset
REQ-024 rst_n low asynchronously sets:
- FSM to IDLE;
- synchronizer flops to 1;
- rx_data_syn, end_flag, frame_err, frame_err_cnt, link_lost, and all counters to 0.
REQ-025 Reset asserted mid-frame abandons the frame; no end_flag or frame_err is produced for it after release.

Structure
REQ-026 Shared package fiber_pkg holds DATA_BITS_SIZES, the FSM state encoding, and the counter-width helper function.
REQ-027 One sub-module, fiber_in_sync: 2-flop synchronizer plus falling-edge detect, reset value 1.

Verification (bench: BIT_CLKS=8, LINK_TIMEOUT_US=20, time_1us every 50 clk)
REQ-028 Send frame 10110 (data 1011, parity 0) -> exactly one end_flag, rx_data_syn=5'b10110, frame_err never set.
REQ-029 Send 3-clk low glitch on idle line -> FSM returns to IDLE, no end_flag, no frame_err.
REQ-030 Send frame 01101 with stop bit forced 0 -> frame_err pulse, frame_err_cnt=1, rx_data_syn keeps prior value 10110.
REQ-031 Send two frames 11110 then 00011 back-to-back with zero idle gap -> two end_flag pulses, values in that order.
REQ-032 Idle line for 21 us -> link_lost=1; send one good frame -> link_lost=0 in the end_flag cycle.
REQ-033 Assert rst_n low during data bit 3 -> all outputs 0; after release, a following good frame 00000 yields end_flag and rx_data_syn=0.
